// File: rtl/wb_pkg.sv
// Shared types and widths for the pipelined Wishbone burst master.
// Address/data widths, FSM state encoding, outstanding-counter width.
package wb_pkg;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;
endpackage

// File: rtl/wb_outstanding_cnt.sv
// Outstanding-strobe counter with strobe gating at the pipeline limit.
// An ack in the same cycle frees a slot, so a full pipe can still issue.
module wb_outstanding_cnt
  import wb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic req,
  input  logic stall,
  input  logic ack,
  output logic stb,
  output logic accept,
  output logic pending,
  output logic last
);

  logic [CW-1:0] cnt;
  logic          full;

  assign full    = (cnt == CW'(MAX)) & ~ack;
  assign stb     = req & ~full;
  assign accept  = stb & ~stall;
  assign pending = (cnt != '0);
  assign last    = (cnt == CW'(1)) & ack & ~accept;

  // count accepted strobes not yet answered by ack or err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (accept & ~ack) begin
      cnt <= cnt + 1'b1;
    end else if (~accept & ack & pending) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/wb_master_pipelined.sv
// Pipelined Wishbone burst master: IDLE -> ISSUE -> DRAIN -> IDLE.
// Optional ack-wait abort is built when WB_MASTER_TIMEOUT_EN is defined.
module wb_master_pipelined
  import wb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_adr,
  input  logic [AW-1:0] cmd_len,
  output logic          busy,
  output logic          done,
  output logic          error,
  input  logic [DW-1:0] wr_dat,
  output logic          wr_pop,
  output logic [DW-1:0] rd_dat,
  output logic          rd_vld,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [AW-1:0] wb_adr,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack,
  input  logic          wb_stall,
  input  logic          wb_err
);

  state_t        state;
  logic [AW-1:0] adr;
  logic [AW-1:0] rem;
  logic          we_q;
  logic          ack_in;
  logic          err_in;
  logic          abort;
  logic          accept;
  logic          pending;
  logic          last;

  assign busy   = (state != IDLE);
  assign ack_in = busy & wb_ack;
  assign err_in = busy & wb_err;

`ifdef WB_MASTER_TIMEOUT_EN
  logic [15:0] tcnt;
  logic        to_hit;

  assign to_hit = busy & pending & ~wb_ack
                & (tcnt == 16'(TIMEOUT - 1));
  assign abort  = err_in | to_hit;

  // cycles spent waiting with strobes in flight and no ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (~busy | wb_ack | ~pending) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  logic unused_to;

  assign unused_to = pending ^ (TIMEOUT != 0);
  assign abort     = err_in;
`endif

  wb_outstanding_cnt #(
    .MAX(MAX_OUTSTANDING)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (abort),
    .req    ((state == ISSUE) & ~abort),
    .stall  (wb_stall),
    .ack    (busy & (wb_ack | wb_err)),
    .stb    (wb_stb),
    .accept (accept),
    .pending(pending),
    .last   (last)
  );

  assign wb_cyc   = busy;
  assign wb_we    = we_q & busy;
  assign wb_adr   = adr;
  assign wb_dat_o = wr_dat;
  assign wr_pop   = accept & wb_we;

  // burst sequencing, address walk and completion status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      adr   <= '0;
      rem   <= '0;
      we_q  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            error <= 1'b0;
            if (cmd_len != '0) begin
              state <= ISSUE;
              adr   <= cmd_adr;
              rem   <= cmd_len;
              we_q  <= cmd_we;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (abort) begin
            state <= IDLE;
            done  <= 1'b1;
            error <= 1'b1;
          end else if (accept) begin
            adr <= adr + 1'b1;
            rem <= rem - 1'b1;
            if (rem == AW'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
            done  <= 1'b1;
            error <= 1'b1;
          end else if (last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // read data is returned one cycle after its ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_dat <= wb_dat_i;
      rd_vld <= ack_in & ~wb_we;
    end
  end

endmodule

// File: doc/wb_master_pipelined.md
WB_MASTER_PIPELINED -- requirements
Module: wb_master_pipelined

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning maximum accepted-but-unacknowledged strobes (1..15).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning ack-wait cycles before abort; used only under the timeout feature.
REQ-003 SHALL have port clk input 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n input 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports start input 1 (command pulse); cmd_we input 1 (1=write burst); cmd_adr input 16 (start word address); cmd_len input 16 (word count).
REQ-006 SHALL have ports busy output 1 (burst in progress); done output 1 (one-cycle completion pulse); error output 1 (status of last burst, valid with done).
REQ-007 SHALL have ports wr_dat input 16 (write word, valid while busy & cmd_we) and wr_pop output 1 (current write word accepted by bus).
REQ-008 SHALL have ports rd_dat output 16 and rd_vld output 1 (one read word per ack).
REQ-009 SHALL have Wishbone pipelined initiator ports: wb_cyc, wb_stb, wb_we output 1; wb_adr output 16; wb_dat_o output 16; wb_dat_i input 16; wb_ack, wb_stall, wb_err input 1.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, DRAIN, with done asserted for exactly one cycle on return to IDLE.
REQ-011 SHALL, in IDLE, on start=1 with cmd_len!=0, latch cmd_we, cmd_adr and cmd_len and enter ISSUE the next cycle; start while busy SHALL be ignored.
REQ-012 SHALL, on start=1 with cmd_len=0, stay in IDLE, pulse done the next cycle with error=0, and drive no bus activity.
REQ-013 SHALL hold wb_cyc=1 throughout ISSUE and DRAIN, and busy = (state!=IDLE).
REQ-014 SHALL treat a strobe as accepted in a cycle with wb_stb & ~wb_stall; on acceptance the address SHALL increment by 1 mod 2^16 and the remaining-issue count SHALL decrement.
REQ-015 SHALL hold wb_adr, wb_we and wb_dat_o stable while wb_stb & wb_stall.
REQ-016 SHALL drive wb_dat_o = wr_dat and wr_pop = wb_stb & ~wb_stall & wb_we combinationally.
REQ-017 SHALL keep an outstanding counter: +1 on acceptance, -1 on wb_ack or wb_err, unchanged when both occur in the same cycle.
REQ-018 SHALL deassert wb_stb when outstanding == MAX_OUTSTANDING, unless an ack arrives in the same cycle.
REQ-019 SHALL enter DRAIN after the last strobe is accepted, and return to IDLE when outstanding reaches 0, including the cycle where the final ack arrives.
REQ-020 SHALL register rd_dat <= wb_dat_i and rd_vld <= wb_ack & ~wb_we, so read data has one cycle of latency after ack.
REQ-021 SHALL, on wb_err in ISSUE or DRAIN, stop issuing immediately, drop wb_cyc and wb_stb the next cycle, discard later acks, and return to IDLE with done=1 and error=1.
REQ-022 SHALL ignore wb_ack and wb_err received in IDLE.

Reset
REQ-023 SHALL, on rst_n=0 at any time including mid-burst, force state IDLE and zero the outstanding and remaining counts.
REQ-024 SHALL, during reset, drive wb_cyc, wb_stb, wb_we, busy, done, error, rd_vld and wr_pop to 0, and wb_adr, rd_dat and the latched address to 0.

Configuration
REQ-025 SHALL, with WB_MASTER_TIMEOUT_EN defined, count cycles with outstanding!=0 and no ack; reaching TIMEOUT SHALL abort exactly as wb_err does (error=1), and the counter SHALL clear on every ack.
REQ-026 SHALL, without WB_MASTER_TIMEOUT_EN, contain no timeout logic, and a burst SHALL wait indefinitely for acks.

Structure
REQ-027 SHALL define the FSM state enum (IDLE, ISSUE, DRAIN) and the address and data width constants (16) in shared package wb_pkg.
REQ-028 SHALL implement the outstanding counter with stall gating as the sub-module wb_outstanding_cnt; everything else SHALL be flat.

Verification
REQ-029 Zero-wait read: slave with waitcycles=0, read cmd_adr=0x0010, len=4 -> wb_adr 0x10..0x13 on consecutive cycles; 4 rd_vld pulses with RAM contents; done one cycle after the last ack.
REQ-030 Stalled write: slave with waitcycles=2, write cmd_adr=0xFFFE, len=3 -> addresses 0xFFFE, 0xFFFF, 0x0000; exactly 3 wr_pop pulses; wb_adr stable during stall.
REQ-031 Outstanding limit: MAX_OUTSTANDING=2, acks delayed 5 cycles, len=6 -> wb_stb low whenever 2 strobes are outstanding; outstanding never exceeds 2.
REQ-032 Error: wb_err on the 2nd ack of len=5 -> no further strobes; wb_cyc low the next cycle; done=1 and error=1.
REQ-033 Boundaries: cmd_len=0 -> done the next cycle with no wb_cyc; rst_n low mid-burst -> all outputs at reset values asynchronously.
REQ-034 Timeout: with WB_MASTER_TIMEOUT_EN and TIMEOUT=8, slave never acks -> abort after 8 cycles with error=1.
